// File: rtl/exe_fwd_hzd.sv
// Execute stage: operand forwarding, barrel shifter, ALU with NZCV status,
// EXE/MEM pipeline register, branch target adder and load-use hazard detection.
module exe_fwd_hzd (
  input  logic        clk,
  input  logic        rst,
  input  logic        FWRD_EN,
  input  logic [31:0] pc,
  input  logic [31:0] rn_val,
  input  logic [31:0] rm_val,
  input  logic [23:0] signed_imm_24,
  input  logic [11:0] shifter_operand,
  input  logic [3:0]  exe_cmd,
  input  logic [3:0]  dest,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        S,
  input  logic        B,
  input  logic        imm,
  input  logic [31:0] val_WB,
  input  logic        WB_EN_WB,
  input  logic [3:0]  dest_WB,
  input  logic [3:0]  src1_HZRD,
  input  logic [3:0]  src2_HZRD,
  input  logic        two_src,
  input  logic        move,
  output logic [31:0] alu_res,
  output logic [31:0] rm_val_out,
  output logic [3:0]  dest_out,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic [31:0] branch_address,
  output logic [3:0]  status,
  output logic        hazard
);

  localparam int DATA_W = 32;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  function automatic logic [DATA_W-1:0] ror_w(input logic [DATA_W-1:0] x,
                                              input logic [4:0]        n);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} >> n;
    return dbl[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_op(input logic signed [DATA_W-1:0] x,
                                                 input logic [4:0]               amt,
                                                 input logic [1:0]               typ);
    logic [DATA_W-1:0] r;
    case (typ)
      2'b00:   r = x << amt;
      2'b01:   r = x >> amt;
      2'b10:   r = x >>> amt;
      default: r = ror_w(x, amt);
    endcase
    return r;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic       en,
                                         input logic [3:0] src,
                                         input logic       mem_wb,
                                         input logic [3:0] mem_dest,
                                         input logic       wb_wb,
                                         input logic [3:0] wb_dest);
    logic [1:0] s;
    s = SEL_REG;
    if (en && mem_wb && (mem_dest == src))
      s = SEL_MEM;
    else if (en && wb_wb && (wb_dest == src))
      s = SEL_WB;
    return s;
  endfunction

  logic [DATA_W-1:0]        alu_res_p1;
  logic [DATA_W-1:0]        rm_val_p1;
  logic [3:0]               dest_p1;
  logic                     wb_en_p1;
  logic                     mem_r_en_p1;
  logic                     mem_w_en_p1;
  logic [3:0]               status_p1;

  logic [1:0]               sel1_p0;
  logic [1:0]               sel2_p0;
  logic signed [DATA_W-1:0] op1_p0;
  logic signed [DATA_W-1:0] fwd_rm_p0;
  logic signed [DATA_W-1:0] val2_p0;
  logic [DATA_W:0]          sum_p0;
  logic [DATA_W-1:0]        res_p0;
  logic                     c_p0;
  logic                     v_p0;
  logic                     hold_p0;
  logic [3:0]               nzcv_p0;
  logic signed [DATA_W-1:0] br_off_p0;
  logic                     hzrd_dis_p0;
  logic                     unused_b;

  assign unused_b = B;

  // Stage p0: operand selection from register file, MEM stage or WB stage
  assign sel1_p0 = fwd_sel(FWRD_EN, src1, wb_en_p1, dest_p1, WB_EN_WB, dest_WB);
  assign sel2_p0 = fwd_sel(FWRD_EN, src2, wb_en_p1, dest_p1, WB_EN_WB, dest_WB);

  always_comb begin
    op1_p0 = rn_val;
    case (sel1_p0)
      SEL_MEM: op1_p0 = alu_res_p1;
      SEL_WB:  op1_p0 = val_WB;
      default: op1_p0 = rn_val;
    endcase
  end

  always_comb begin
    fwd_rm_p0 = rm_val;
    case (sel2_p0)
      SEL_MEM: fwd_rm_p0 = alu_res_p1;
      SEL_WB:  fwd_rm_p0 = val_WB;
      default: fwd_rm_p0 = rm_val;
    endcase
  end

  // Memory accesses take the raw 12-bit offset; otherwise rotated immediate or shifted register
  always_comb begin
    val2_p0 = '0;
    if (MEM_R_EN || MEM_W_EN)
      val2_p0 = {20'b0, shifter_operand};
    else if (imm)
      val2_p0 = ror_w({24'b0, shifter_operand[7:0]}, {shifter_operand[11:8], 1'b0});
    else
      val2_p0 = shift_op(fwd_rm_p0, shifter_operand[11:7], shifter_operand[6:5]);
  end

  // Subtraction is op1 + ~val2 + carry-in, so C comes out as NOT borrow directly
  always_comb begin
    sum_p0  = '0;
    res_p0  = '0;
    c_p0    = status_p1[1];
    v_p0    = status_p1[0];
    hold_p0 = 1'b0;
    case (exe_cmd)
      CMD_MOV: res_p0 = val2_p0;
      CMD_MVN: res_p0 = ~val2_p0;
      CMD_AND: res_p0 = op1_p0 & val2_p0;
      CMD_ORR: res_p0 = op1_p0 | val2_p0;
      CMD_EOR: res_p0 = op1_p0 ^ val2_p0;
      CMD_ADD: begin
        sum_p0 = {1'b0, op1_p0} + {1'b0, val2_p0};
        res_p0 = sum_p0[DATA_W-1:0];
        c_p0   = sum_p0[DATA_W];
        v_p0   = (op1_p0[DATA_W-1] == val2_p0[DATA_W-1]) &&
                 (res_p0[DATA_W-1] != op1_p0[DATA_W-1]);
      end
      CMD_ADC: begin
        sum_p0 = {1'b0, op1_p0} + {1'b0, val2_p0} + {{DATA_W{1'b0}}, status_p1[1]};
        res_p0 = sum_p0[DATA_W-1:0];
        c_p0   = sum_p0[DATA_W];
        v_p0   = (op1_p0[DATA_W-1] == val2_p0[DATA_W-1]) &&
                 (res_p0[DATA_W-1] != op1_p0[DATA_W-1]);
      end
      CMD_SUB: begin
        sum_p0 = {1'b0, op1_p0} + {1'b0, ~val2_p0} + {{DATA_W{1'b0}}, 1'b1};
        res_p0 = sum_p0[DATA_W-1:0];
        c_p0   = sum_p0[DATA_W];
        v_p0   = (op1_p0[DATA_W-1] != val2_p0[DATA_W-1]) &&
                 (res_p0[DATA_W-1] != op1_p0[DATA_W-1]);
      end
      CMD_SBC: begin
        sum_p0 = {1'b0, op1_p0} + {1'b0, ~val2_p0} + {{DATA_W{1'b0}}, status_p1[1]};
        res_p0 = sum_p0[DATA_W-1:0];
        c_p0   = sum_p0[DATA_W];
        v_p0   = (op1_p0[DATA_W-1] != val2_p0[DATA_W-1]) &&
                 (res_p0[DATA_W-1] != op1_p0[DATA_W-1]);
      end
      default: hold_p0 = 1'b1;
    endcase
  end

  assign nzcv_p0 = hold_p0 ? status_p1
                           : {res_p0[DATA_W-1], (res_p0 == '0), c_p0, v_p0};

  assign br_off_p0      = {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign branch_address = pc + br_off_p0;

  // With forwarding active, only a load in EXE forces a stall
  assign hzrd_dis_p0 = FWRD_EN && !MEM_R_EN;
  assign hazard = !hzrd_dis_p0 &&
                  ((!move   && (src1_HZRD == dest)    && WB_EN)    ||
                   (!move   && (src1_HZRD == dest_p1) && wb_en_p1) ||
                   (two_src && (src2_HZRD == dest)    && WB_EN)    ||
                   (two_src && (src2_HZRD == dest_p1) && wb_en_p1));

  // Stage p1: EXE/MEM register and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_res_p1  <= '0;
      rm_val_p1   <= '0;
      dest_p1     <= '0;
      wb_en_p1    <= 1'b0;
      mem_r_en_p1 <= 1'b0;
      mem_w_en_p1 <= 1'b0;
      status_p1   <= '0;
    end else begin
      alu_res_p1  <= hold_p0 ? '0 : res_p0;
      rm_val_p1   <= fwd_rm_p0;
      dest_p1     <= dest;
      wb_en_p1    <= WB_EN;
      mem_r_en_p1 <= MEM_R_EN;
      mem_w_en_p1 <= MEM_W_EN;
      if (S)
        status_p1 <= nzcv_p0;
    end
  end

  assign alu_res      = alu_res_p1;
  assign rm_val_out   = rm_val_p1;
  assign dest_out     = dest_p1;
  assign WB_EN_out    = wb_en_p1;
  assign MEM_R_EN_out = mem_r_en_p1;
  assign MEM_W_EN_out = mem_w_en_p1;
  assign status       = status_p1;

endmodule

// File: tb/tb_exe_fwd_hzd.sv
// Bench for exe_fwd_hzd: directed vector table, reset sequences and a
// randomized run against an arithmetic reference model.
module tb_exe_fwd_hzd;

  logic        clk = 1'b0;
  logic        rst;
  logic        FWRD_EN;
  logic [31:0] pc, rn_val, rm_val, val_WB;
  logic [23:0] signed_imm_24;
  logic [11:0] shifter_operand;
  logic [3:0]  exe_cmd, dest, src1, src2, dest_WB, src1_HZRD, src2_HZRD;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, S, B, imm, WB_EN_WB, two_src, move;
  logic [31:0] alu_res, rm_val_out, branch_address;
  logic [3:0]  dest_out, status;
  logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, hazard;

  always #5 clk = ~clk;

  exe_fwd_hzd dut (
    .clk(clk), .rst(rst), .FWRD_EN(FWRD_EN), .pc(pc), .rn_val(rn_val), .rm_val(rm_val),
    .signed_imm_24(signed_imm_24), .shifter_operand(shifter_operand), .exe_cmd(exe_cmd),
    .dest(dest), .src1(src1), .src2(src2), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .S(S), .B(B), .imm(imm), .val_WB(val_WB), .WB_EN_WB(WB_EN_WB),
    .dest_WB(dest_WB), .src1_HZRD(src1_HZRD), .src2_HZRD(src2_HZRD), .two_src(two_src),
    .move(move), .alu_res(alu_res), .rm_val_out(rm_val_out), .dest_out(dest_out),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .branch_address(branch_address), .status(status), .hazard(hazard)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        fen;
    logic [31:0] pc, rn, rm;
    logic [23:0] imm24;
    logic [11:0] so;
    logic [3:0]  cmd, dst, s1, s2;
    logic        wb, mr, mw, s, imm;
    logic [31:0] vwb;
    logic        wbwb;
    logic [3:0]  dwb, s1h, s2h;
    logic        two, mv;
    logic [31:0] e_alu, e_rm;
    logic [3:0]  e_st;
    logic        e_haz;
    logic [31:0] e_br;
  } vec_t;

  vec_t tbl[13];

  task automatic apply(input vec_t v);
    FWRD_EN = v.fen; pc = v.pc; rn_val = v.rn; rm_val = v.rm; signed_imm_24 = v.imm24;
    shifter_operand = v.so; exe_cmd = v.cmd; dest = v.dst; src1 = v.s1; src2 = v.s2;
    WB_EN = v.wb; MEM_R_EN = v.mr; MEM_W_EN = v.mw; S = v.s; B = 1'b0; imm = v.imm;
    val_WB = v.vwb; WB_EN_WB = v.wbwb; dest_WB = v.dwb; src1_HZRD = v.s1h;
    src2_HZRD = v.s2h; two_src = v.two; move = v.mv;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_alu, m_rm;
  logic [3:0]  m_dest, m_status;
  logic        m_wb, m_mr, m_mw;

  function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_val2(input logic mem, input logic im,
                                         input logic [11:0] so, input logic [31:0] x);
    int amt;
    amt = int'(so[11:7]);
    if (mem) return {20'b0, so};
    if (im) return m_ror({24'b0, so[7:0]}, 2 * int'(so[11:8]));
    case (so[6:5])
      2'd0:    return x << amt;
      2'd1:    return x >> amt;
      2'd2:    return x[31] ? ~((~x) >> amt) : (x >> amt);
      default: return m_ror(x, amt);
    endcase
  endfunction

  function automatic logic [31:0] m_fwd(input logic [3:0] src, input logic [31:0] regv);
    if (FWRD_EN && m_wb && m_dest == src) return m_alu;
    if (FWRD_EN && WB_EN_WB && dest_WB == src) return val_WB;
    return regv;
  endfunction

  task automatic m_exec(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] st, output logic [31:0] res, output logic [3:0] f);
    longint unsigned ua, ub, u;
    longint          sa, sb, s;
    logic            c, v, arith;
    longint unsigned bw;
    ua = {32'b0, a}; ub = {32'b0, b};
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = st[1]; v = st[0]; arith = 1'b0; res = '0; u = 0; s = 0;
    bw = st[1] ? 64'd0 : 64'd1;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      4'd2: begin u = ua + ub; s = sa + sb; c = (u >> 32) != 0; arith = 1'b1; end
      4'd3: begin u = ua + ub + {63'b0, st[1]}; s = sa + sb + longint'({63'b0, st[1]});
                  c = (u >> 32) != 0; arith = 1'b1; end
      4'd4: begin u = ua - ub; s = sa - sb; c = ua >= ub; arith = 1'b1; end
      4'd5: begin u = ua - ub - bw; s = sa - sb - longint'(bw); c = ua >= ub + bw;
                  arith = 1'b1; end
      default: begin res = '0; f = st; return; end
    endcase
    if (arith) begin
      res = u[31:0];
      v = (s != longint'($signed(res)));
    end
    f = {res[31], res == 32'd0, c, v};
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    vec_t        v;
    logic [31:0] op1, fr, v2, res, exp_br;
    logic [3:0]  f;
    logic        exp_haz;
    int          off;

    v = '0; v.cmd = 4'd2; v.s = 1; v.rn = 32'h7FFF_FFFF; v.imm = 1; v.so = 12'h001; v.dst = 4'd1;
    v.wb = 1; v.e_alu = 32'h8000_0000; v.e_st = 4'b1001; tbl[0] = v;
    v = '0; v.cmd = 4'd4; v.s = 1; v.rn = 32'd5; v.rm = 32'd5; v.s1 = 4'd2; v.s2 = 4'd3;
    v.dst = 4'd2; v.wb = 1; v.e_rm = 32'd5; v.e_st = 4'b0110; tbl[1] = v;
    v = '0; v.cmd = 4'd1; v.imm = 1; v.so = 12'h2FF; v.dst = 4'd4; v.e_alu = 32'hF000_000F;
    v.e_st = 4'b0110; tbl[2] = v;
    v = '0; v.cmd = 4'd2; v.mw = 1; v.imm = 1; v.rn = 32'h100; v.so = 12'h2FF; v.dst = 4'd4;
    v.e_alu = 32'h3FF; v.e_st = 4'b0110; tbl[3] = v;
    v = '0; v.cmd = 4'd8; v.s = 1; v.rn = 32'hFFFF_0000; v.rm = 32'h0F0F_0F0F; v.pc = 32'h100;
    v.imm24 = 24'hFFFFFE; v.e_alu = 32'hF0F0_0F0F; v.e_rm = 32'h0F0F_0F0F; v.e_st = 4'b1010;
    v.e_br = 32'hF8; tbl[4] = v;
    v = '0; v.fen = 1; v.mr = 1; v.wb = 1; v.dst = 4'd2; v.s1h = 4'd2; v.cmd = 4'd2;
    v.rn = 32'h10; v.so = 12'h004; v.e_alu = 32'h14; v.e_st = 4'b1010; v.e_haz = 1; tbl[5] = v;
    v = '0; v.fen = 1; v.wb = 1; v.dst = 4'd3; v.s1h = 4'd2; v.cmd = 4'd2;
    v.rn = 32'h10; v.so = 12'h004; v.e_alu = 32'h10; v.e_st = 4'b1010; tbl[6] = v;
    v = '0; v.fen = 1; v.s1 = 4'd3; v.wbwb = 1; v.dwb = 4'd3; v.vwb = 32'hDEAD_0000;
    v.rn = 32'h1111; v.cmd = 4'd2; v.imm = 1; v.dst = 4'd3; v.wb = 1; v.e_alu = 32'h10;
    v.e_st = 4'b1010; tbl[7] = v;
    v.fen = 0; v.e_alu = 32'h1111; tbl[8] = v;
    v = '0; v.two = 1; v.s2h = 4'd3; v.cmd = 4'd0; v.s = 1; v.rn = 32'h55; v.dst = 4'd5;
    v.wb = 1; v.e_st = 4'b1010; v.e_haz = 1; tbl[9] = v;
    v = '0; v.fen = 1; v.s2 = 4'd7; v.dwb = 4'd7; v.wbwb = 1; v.vwb = 32'h80;
    v.rm = 32'h1234_5678; v.rn = 32'h1; v.cmd = 4'd7; v.so = 12'h220; v.e_alu = 32'h9;
    v.e_rm = 32'h80; v.e_st = 4'b1010; tbl[10] = v;
    v = '0; v.cmd = 4'd5; v.s = 1; v.rm = 32'h8000_0000; v.so = 12'hFC0; v.e_alu = 32'h1;
    v.e_rm = 32'h8000_0000; v.e_st = 4'b0000; tbl[11] = v;
    v = '0; v.cmd = 4'd9; v.s = 1; v.rm = 32'hF; v.so = 12'h260; v.e_alu = 32'h0FFF_FFFF;
    v.e_rm = 32'hF; v.e_st = 4'b0000; tbl[12] = v;

    // reset state
    rst = 1'b0;
    v = '0; apply(v);
    #12;
    chk("rst_alu", alu_res, 32'h0);
    chk("rst_rm", rm_val_out, 32'h0);
    chk("rst_dest", 32'(dest_out), 32'h0);
    chk("rst_ctl", 32'({WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_hazard", 32'(hazard), 32'h0);
    @(negedge clk); rst = 1'b1;

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(tbl[i].e_haz));
      chk($sformatf("v%0d_branch", i), branch_address, tbl[i].e_br);
      @(posedge clk); #1;
      chk($sformatf("v%0d_alu", i), alu_res, tbl[i].e_alu);
      chk($sformatf("v%0d_rm", i), rm_val_out, tbl[i].e_rm);
      chk($sformatf("v%0d_status", i), 32'(status), 32'(tbl[i].e_st));
      chk($sformatf("v%0d_dest", i), 32'(dest_out), 32'(tbl[i].dst));
      chk($sformatf("v%0d_ctl", i), 32'({WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}),
          32'({tbl[i].wb, tbl[i].mr, tbl[i].mw}));
    end

    // reset asserted mid-stream
    v = '0; v.cmd = 4'd2; v.s = 1; v.rn = 32'h8000_0000; v.mr = 1; v.mw = 1; v.dst = 4'd9;
    v.wb = 1; v.rm = 32'hABCD; apply(v);
    @(posedge clk); #1;
    chk("pre_rst_alu", alu_res, 32'h8000_0000);
    chk("pre_rst_status", 32'(status), 32'h8);
    chk("pre_rst_dest", 32'(dest_out), 32'd9);
    FWRD_EN = 0; two_src = 1; src2_HZRD = 4'd9; WB_EN = 0; dest = 4'd0;
    pc = 32'h40; signed_imm_24 = 24'h1;
    #1;
    chk("pre_rst_hazard", 32'(hazard), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_alu", alu_res, 32'h0);
    chk("mid_rst_rm", rm_val_out, 32'h0);
    chk("mid_rst_dest", 32'(dest_out), 32'h0);
    chk("mid_rst_ctl", 32'({WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}), 32'h0);
    chk("mid_rst_status", 32'(status), 32'h0);
    chk("mid_rst_hazard", 32'(hazard), 32'h0);
    chk("mid_rst_branch", branch_address, 32'h44);
    @(posedge clk); #1;
    chk("hold_rst_alu", alu_res, 32'h0);
    chk("hold_rst_dest", 32'(dest_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    v = '0; v.cmd = 4'd9; v.imm = 1; v.s = 1; v.dst = 4'd6; v.wb = 1; apply(v);
    @(posedge clk); #1;
    chk("post_rst_alu", alu_res, 32'hFFFF_FFFF);
    chk("post_rst_status", 32'(status), 32'h8);
    chk("post_rst_dest", 32'(dest_out), 32'd6);

    // randomized run against the model
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    m_alu = '0; m_rm = '0; m_dest = '0; m_wb = 0; m_mr = 0; m_mw = 0; m_status = '0;
    for (int n = 0; n < 400; n++) begin
      FWRD_EN = ($urandom_range(0, 3) != 0);
      pc = $urandom(); rn_val = rnd_word(); rm_val = rnd_word(); val_WB = rnd_word();
      signed_imm_24 = 24'($urandom()); shifter_operand = 12'($urandom());
      exe_cmd = 4'($urandom());
      dest = 4'($urandom_range(0, 3)); src1 = 4'($urandom_range(0, 3));
      src2 = 4'($urandom_range(0, 3)); dest_WB = 4'($urandom_range(0, 3));
      src1_HZRD = 4'($urandom_range(0, 3)); src2_HZRD = 4'($urandom_range(0, 3));
      WB_EN = 1'($urandom()); MEM_R_EN = ($urandom_range(0, 3) == 0);
      MEM_W_EN = ($urandom_range(0, 3) == 0); S = 1'($urandom()); B = 1'($urandom());
      imm = 1'($urandom()); WB_EN_WB = 1'($urandom()); two_src = 1'($urandom());
      move = 1'($urandom());
      #1;
      exp_haz = 1'b0;
      if (!(FWRD_EN && !MEM_R_EN))
        exp_haz = (!move && src1_HZRD == dest && WB_EN) ||
                  (!move && src1_HZRD == m_dest && m_wb) ||
                  (two_src && src2_HZRD == dest && WB_EN) ||
                  (two_src && src2_HZRD == m_dest && m_wb);
      off = int'(signed_imm_24);
      if (signed_imm_24[23]) off = off - 16777216;
      exp_br = pc + 32'(off * 4);
      chk("rnd_hazard", 32'(hazard), 32'(exp_haz));
      chk("rnd_branch", branch_address, exp_br);
      op1 = m_fwd(src1, rn_val);
      fr  = m_fwd(src2, rm_val);
      v2  = m_val2(MEM_R_EN || MEM_W_EN, imm, shifter_operand, fr);
      m_exec(exe_cmd, op1, v2, m_status, res, f);
      @(posedge clk);
      m_alu = res; m_rm = fr; m_dest = dest; m_wb = WB_EN; m_mr = MEM_R_EN; m_mw = MEM_W_EN;
      if (S) m_status = f;
      #1;
      chk("rnd_alu", alu_res, m_alu);
      chk("rnd_rm", rm_val_out, m_rm);
      chk("rnd_status", 32'(status), 32'(m_status));
      chk("rnd_dest", 32'(dest_out), 32'(m_dest));
      chk("rnd_ctl", 32'({WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}), 32'({m_wb, m_mr, m_mw}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
